ssd_probe_display: RTL and testbench

- Parametrised debug display unit that replaces the fixed 12-way ssd_sel case/SSD pairing at CPU top level.
- Selects one of NUM_PROBES datapath probes of PROBE_W bits and scans it as hex onto a DIGITS-digit multiplexed seven-segment display.
- Pages through probes wider than the display, with optional snapshot/freeze of the shown value.
- Sits in the top level beside the core; probes are driven by pc, rs1/rs2 data, imm, alu result, mem out, etc.

---
 rtl/ssd_probe_pkg.sv | 50 +++++
 rtl/ssd_digit_scanner.sv | 44 ++++
 rtl/ssd_probe_display.sv | 112 +++++++++++
 tb/tb_ssd_probe_display.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_probe_pkg.sv
// ssd_probe_pkg: shared constants for the probe display.
//   SEG_0..SEG_F - active-low hex glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_DASH     - centre bar only, shown for an invalid probe selection
//   SEG_OFF      - all segments dark
//   hex_to_seg() - nibble to glyph lookup
package ssd_probe_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_A    = 7'h08;
    localparam logic [6:0] SEG_B    = 7'h03;
    localparam logic [6:0] SEG_C    = 7'h46;
    localparam logic [6:0] SEG_D    = 7'h21;
    localparam logic [6:0] SEG_E    = 7'h06;
    localparam logic [6:0] SEG_F    = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] glyph;
        unique case (nibble)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/ssd_digit_scanner.sv
// ssd_digit_scanner: time-multiplexes the digits of the display.
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   digit_idx - digit currently being scanned (0 = least significant)
//   anode     - registered one-hot active-low digit enable for digit_idx
// Each digit stays selected for REFRESH_DIV cycles before moving on.
module ssd_digit_scanner #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    localparam int DIG_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [DIG_W-1:0]  digit_idx,
    output logic [DIGITS-1:0] anode
);
    import ssd_probe_pkg::*;

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(DIGITS - 1);

    logic [CNT_W-1:0] refresh_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; all state here is reset since it drives pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            anode       <= '1;
        end else begin
            // Anode follows the index one cycle later, aligned with the seg register.
            anode <= ~(DIGITS'(1) << digit_idx);
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == DIG_MAX) ? '0 : digit_idx + DIG_W'(1);
            end else begin
                refresh_cnt <= refresh_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/ssd_probe_display.sv
// ssd_probe_display: debug display that shows one of NUM_PROBES datapath probes
// as hex on a DIGITS-digit multiplexed seven-segment display.
//   clk, rst     - system clock, asynchronous active-low reset
//   probes       - flattened probes, probe k at [k*PROBE_W +: PROBE_W]
//   probe_sel    - probe index; codes >= NUM_PROBES show dashes
//   page_btn     - synchronised level; each rising edge advances the page
//   capture_stb  - one-cycle pulse, snapshots the live selected probe
//   freeze       - 1 shows the snapshot, 0 shows the live probe
//   anode, seg   - active-low digit enables and segments {g,f,e,d,c,b,a}
//   page         - page of DIGITS nibbles currently shown
//   sel_valid    - probe_sel is in range (combinational)
module ssd_probe_display #(
    parameter int NUM_PROBES  = 16,
    parameter int PROBE_W     = 32,
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int SEL_W       = $clog2(NUM_PROBES) + 1,
    localparam int PAGES      = (PROBE_W + 4*DIGITS - 1) / (4*DIGITS),
    localparam int PAGE_W     = (PAGES > 1) ? $clog2(PAGES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PROBES*PROBE_W-1:0] probes,
    input  logic [SEL_W-1:0]              probe_sel,
    input  logic                          page_btn,
    input  logic                          capture_stb,
    input  logic                          freeze,
    output logic [DIGITS-1:0]             anode,
    output logic [6:0]                    seg,
    output logic [PAGE_W-1:0]             page,
    output logic                          sel_valid
);
    import ssd_probe_pkg::*;

    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int NIBS   = PAGES * DIGITS;
    localparam int PAD_W  = NIBS * 4;
    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(PAGES - 1);

    logic [DIG_W-1:0]   digit_idx;
    logic [PROBE_W-1:0] live;
    logic [PROBE_W-1:0] snapshot;
    logic [PROBE_W-1:0] shown;
    logic [PAD_W-1:0]   padded;
    logic [3:0]         nibble;
    logic               btn_prev;
    logic [SEL_W-1:0]   sel_prev;
    logic               page_rise;
    logic               sel_changed;

    ssd_digit_scanner #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .digit_idx (digit_idx),
        .anode     (anode)
    );

    assign sel_valid = (probe_sel < SEL_W'(NUM_PROBES));

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        live = '0;
        for (int k = 0; k < NUM_PROBES; k++) begin
            if (probe_sel == SEL_W'(k)) live = probes[k*PROBE_W +: PROBE_W];
        end
    end

    assign shown  = freeze ? snapshot : live;
    // Zero-extend so nibbles past PROBE_W on the last page read as 0.
    assign padded = PAD_W'(shown);

    always_comb begin
        nibble = '0;
        for (int n = 0; n < NIBS; n++) begin
            if (n == int'(page) * DIGITS + int'(digit_idx)) nibble = padded[n*4 +: 4];
        end
    end

    assign page_rise   = page_btn & ~btn_prev;
    assign sel_changed = (probe_sel != sel_prev);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_prev <= 1'b0;
            sel_prev <= '0;
            page     <= '0;
            snapshot <= '0;
            seg      <= SEG_OFF;
        end else begin
            btn_prev <= page_btn;
            sel_prev <= probe_sel;

            // A new probe always starts on its low page, even if the button rose too.
            if (sel_changed) begin
                page <= '0;
            end else if (page_rise) begin
                page <= (page == PAGE_MAX) ? '0 : page + PAGE_W'(1);
            end

            if (capture_stb && sel_valid) begin
                snapshot <= live;
            end

            seg <= sel_valid ? hex_to_seg(nibble) : SEG_DASH;
        end
    end

endmodule

// File: tb/tb_ssd_probe_display.sv
// tb_ssd_probe_display: directed self-checking bench for ssd_probe_display
// with a short refresh divider so a full scan takes 16 cycles.
module tb_ssd_probe_display;

    localparam int NUM_PROBES  = 16;
    localparam int PROBE_W     = 32;
    localparam int DIGITS      = 4;
    localparam int REFRESH_DIV = 4;
    localparam int SEL_W       = 5;
    localparam int BOUND       = 40;

    localparam logic [6:0] G_OFF  = 7'h7F;
    localparam logic [6:0] G_DASH = 7'b0111111;
    localparam logic [6:0] G_0    = 7'b1000000;
    localparam logic [6:0] G_5    = 7'b0010010;
    localparam logic [6:0] G_6    = 7'b0000010;
    localparam logic [6:0] G_7    = 7'b1111000;
    localparam logic [6:0] G_8    = 7'b0000000;
    localparam logic [6:0] G_9    = 7'b0010000;
    localparam logic [6:0] G_A    = 7'b0001000;
    localparam logic [6:0] G_B    = 7'b0000011;
    localparam logic [6:0] G_D    = 7'b0100001;
    localparam logic [6:0] G_E    = 7'b0000110;
    localparam logic [6:0] G_F    = 7'b0001110;

    logic                          clk;
    logic                          rst;
    logic [NUM_PROBES*PROBE_W-1:0] probes;
    logic [SEL_W-1:0]              probe_sel;
    logic                          page_btn;
    logic                          capture_stb;
    logic                          freeze;
    logic [DIGITS-1:0]             anode;
    logic [6:0]                    seg;
    logic [0:0]                    page;
    logic                          sel_valid;

    int n_checks = 0;
    int n_fail   = 0;

    ssd_probe_display #(
        .NUM_PROBES  (NUM_PROBES),
        .PROBE_W     (PROBE_W),
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .probes      (probes),
        .probe_sel   (probe_sel),
        .page_btn    (page_btn),
        .capture_stb (capture_stb),
        .freeze      (freeze),
        .anode       (anode),
        .seg         (seg),
        .page        (page),
        .sel_valid   (sel_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Let inputs propagate through page/seg registers, then wait for digit d.
    task automatic expect_digit(input int d, input logic [6:0] exp, input string tag);
        logic [3:0] tgt;
        int guard;
        tgt = ~(4'b0001 << d);
        repeat (2) @(negedge clk);
        guard = 0;
        while (anode !== tgt && guard < BOUND) begin
            @(negedge clk);
            guard++;
        end
        if (anode !== tgt) check({tag, "_timeout"}, 32'(anode), 32'(tgt));
        else               check(tag, 32'(seg), 32'(exp));
    endtask

    task automatic set_probe(input int k, input logic [31:0] v);
        probes[k*PROBE_W +: PROBE_W] = v;
    endtask

    initial begin
        int hold;
        int period;
        int guard;

        rst         = 1'b0;
        probes      = '0;
        probe_sel   = 5'd3;
        page_btn    = 1'b0;
        capture_stb = 1'b0;
        freeze      = 1'b0;
        set_probe(3, 32'hDEADBEEF);
        set_probe(4, 32'h0000_0009);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_seg", 32'(seg), 32'(G_OFF));
        check("rst_page", 32'(page), 32'd0);
        check("rst_sel_valid", 32'(sel_valid), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("first_anode", 32'(anode), 32'hE);
        check("first_seg", 32'(seg), 32'(G_F));

        // Digit dwell time and full scan period, measured from a fresh entry to digit 0
        guard = 0;
        while (anode === 4'hE && guard < BOUND) begin @(negedge clk); guard++; end
        while (anode !== 4'hE && guard < BOUND) begin @(negedge clk); guard++; end
        hold = 0;
        while (anode === 4'hE && hold < BOUND) begin @(negedge clk); hold++; end
        period = hold;
        while (anode !== 4'hE && period < BOUND) begin @(negedge clk); period++; end
        check("dwell_cycles", 32'(hold), 32'd4);
        check("scan_period", 32'(period), 32'd16);

        // Live display of DEADBEEF, page 0
        expect_digit(0, G_F, "live_d0");
        expect_digit(1, G_E, "live_d1");
        expect_digit(2, G_E, "live_d2");
        expect_digit(3, G_B, "live_d3");

        // Paging
        page_btn = 1'b1;
        @(negedge clk);
        check("page_after_rise", 32'(page), 32'd1);
        page_btn = 1'b0;
        expect_digit(0, G_D, "page1_d0");
        expect_digit(1, G_A, "page1_d1");
        expect_digit(2, G_E, "page1_d2");
        expect_digit(3, G_D, "page1_d3");
        page_btn = 1'b1;
        @(negedge clk);
        check("page_wrap", 32'(page), 32'd0);
        page_btn = 1'b0;
        @(negedge clk);
        page_btn  = 1'b1;
        probe_sel = 5'd4;
        @(negedge clk);
        check("page_rise_with_sel_change", 32'(page), 32'd0);
        page_btn = 1'b0;
        expect_digit(0, G_9, "probe4_d0");
        page_btn = 1'b1;
        @(negedge clk);
        check("page_probe4_rise", 32'(page), 32'd1);
        page_btn  = 1'b0;
        probe_sel = 5'd3;
        @(negedge clk);
        check("page_sel_change", 32'(page), 32'd0);

        // Snapshot and freeze
        set_probe(3, 32'h12345678);
        capture_stb = 1'b1;
        @(negedge clk);
        capture_stb = 1'b0;
        freeze      = 1'b1;
        set_probe(3, 32'h0);
        expect_digit(0, G_8, "frozen_d0");
        expect_digit(1, G_7, "frozen_d1");
        expect_digit(2, G_6, "frozen_d2");
        expect_digit(3, G_5, "frozen_d3");
        freeze = 1'b0;
        expect_digit(0, G_0, "unfrozen_d0");
        expect_digit(3, G_0, "unfrozen_d3");

        // Out-of-range selection
        probe_sel = 5'd20;
        #1;
        check("oor_sel_valid", 32'(sel_valid), 32'd0);
        expect_digit(0, G_DASH, "oor_d0");
        expect_digit(2, G_DASH, "oor_d2");
        freeze = 1'b1;
        expect_digit(1, G_DASH, "oor_frozen_d1");
        capture_stb = 1'b1;
        @(negedge clk);
        capture_stb = 1'b0;
        probe_sel   = 5'd3;
        expect_digit(0, G_8, "snap_kept_d0");
        expect_digit(3, G_5, "snap_kept_d3");
        freeze = 1'b0;

        // Asynchronous reset in the middle of digit 2
        guard = 0;
        while (anode !== 4'hB && guard < BOUND) begin @(negedge clk); guard++; end
        check("reach_digit2", 32'(anode), 32'hB);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_anode", 32'(anode), 32'hF);
        check("async_rst_seg", 32'(seg), 32'(G_OFF));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart_anode", 32'(anode), 32'hE);
        repeat (4) @(negedge clk);
        check("restart_next_digit", 32'(anode), 32'hD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
